countdown_timer_core: RTL and testbench

Parametrised mm:ss timer core for the board-level stopwatch/timer tops. Counts down (or up) from a user-set preset, driven by a one-cycle time-base tick from the clock divider, with set, start and pause controls from debounced one-pulse push-buttons and a level mode switch. Outputs packed BCD minutes/seconds for the 7-segment scanner, plus status and LED drive. It replaces ad-hoc counter logic inside each top.

---
 rtl/timer_pkg.sv | 48 ++++
 rtl/bcd_mod_counter.sv | 68 ++++++
 rtl/countdown_timer_core.sv | 184 ++++++++++++++++++
 tb/tb_countdown_timer_core.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and BCD digit helpers for the mm:ss timer core.
//   timer_state_t : top-level FSM states
//   bcd_digit_t   : one packed BCD digit (0..9)
//   bcd_step_t    : digit result plus carry/borrow flag
//   bcd_inc_mod   : digit + 1, wrapping to 0 above max (flag = carry)
//   bcd_dec_mod   : digit - 1, wrapping to max below 0 (flag = borrow)
package timer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSet,
    StRun,
    StPause,
    StDone
  } timer_state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    logic       flag;
    bcd_digit_t digit;
  } bcd_step_t;

  function automatic bcd_step_t bcd_inc_mod(input bcd_digit_t d, input bcd_digit_t max);
    bcd_step_t r;
    if (d >= max) begin
      r.flag  = 1'b1;
      r.digit = '0;
    end else begin
      r.flag  = 1'b0;
      r.digit = d + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_step_t bcd_dec_mod(input bcd_digit_t d, input bcd_digit_t max);
    bcd_step_t r;
    if (d == '0) begin
      r.flag  = 1'b1;
      r.digit = max;
    end else begin
      r.flag  = 1'b0;
      r.digit = d - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed BCD counter, modulo MAX+1 (MAX <= 99).
//   clk_i, rst_ni : clock, async active-low reset (value -> 00)
//   inc_i / dec_i : step up / down by one (inc has priority)
//   load_i        : load load_val_i (priority over inc/dec)
//   value_o       : registered {tens, ones} BCD value
//   wrap_o        : combinational; high when this cycle's step wraps MAX<->00
module bcd_mod_counter
  import timer_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] value_o,
  output logic       wrap_o
);

  localparam bcd_digit_t MaxTens = bcd_digit_t'(MAX / 10);
  localparam bcd_digit_t MaxOnes = bcd_digit_t'(MAX % 10);
  localparam logic [7:0] MaxVal  = {MaxTens, MaxOnes};

  logic [7:0] value_d, value_q;
  bcd_step_t  ones_step, tens_step;

  always_comb begin
    value_d   = value_q;
    wrap_o    = 1'b0;
    ones_step = '0;
    tens_step = '0;
    if (load_i) begin
      value_d = load_val_i;
    end else if (inc_i) begin
      if (value_q == MaxVal) begin
        value_d = '0;
        wrap_o  = 1'b1;
      end else begin
        // Below MAX the digits behave as plain decimal with ones->tens carry.
        ones_step = bcd_inc_mod(value_q[3:0], 4'd9);
        tens_step = bcd_inc_mod(value_q[7:4], 4'd9);
        value_d   = {(ones_step.flag ? tens_step.digit : value_q[7:4]), ones_step.digit};
      end
    end else if (dec_i) begin
      if (value_q == 8'h00) begin
        value_d = MaxVal;
        wrap_o  = 1'b1;
      end else begin
        ones_step = bcd_dec_mod(value_q[3:0], 4'd9);
        tens_step = bcd_dec_mod(value_q[7:4], 4'd9);
        value_d   = {(ones_step.flag ? tens_step.digit : value_q[7:4]), ones_step.digit};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/countdown_timer_core.sv
// mm:ss countdown / count-up timer core.
//   clk, rst_n        : clock, async active-low reset
//   tick              : one-cycle time-base enable (TICKS_PER_SEC per second)
//   set_mode          : level, edit the display
//   inc_sec / inc_min : one-cycle pulses, edit seconds / minutes in SET
//   start / pause     : one-cycle control pulses
//   count_up          : direction level, latched on start from IDLE
//   min_bcd / sec_bcd : registered BCD display
//   running / expired : registered status (RUN / DONE)
//   led               : rotating one-hot in RUN/PAUSE, all ones in DONE
module countdown_timer_core
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned MAX_MIN       = 59,
  parameter int unsigned LED_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             set_mode,
  input  logic             inc_sec,
  input  logic             inc_min,
  input  logic             start,
  input  logic             pause,
  input  logic             count_up,
  output logic [7:0]       min_bcd,
  output logic [7:0]       sec_bcd,
  output logic             running,
  output logic             expired,
  output logic [LED_W-1:0] led
);

  localparam int unsigned   SubW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SubW-1:0] SubLast = SubW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    MaxMinBcd = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  timer_state_t    state_d, state_q;
  logic [SubW-1:0] sub_d, sub_q;
  logic [7:0]      preset_min_d, preset_min_q;
  logic [7:0]      preset_sec_d, preset_sec_q;
  logic            dir_up_d, dir_up_q;
  logic [LED_W-1:0] led_d, led_q;
  logic            running_q, expired_q;

  logic [7:0] min_val, sec_val;
  logic       step, cnt_load, set_edit;
  logic       sec_inc, sec_dec, min_inc, min_dec;
  logic       sec_wrap, min_wrap_unused;
  logic       start_blocked, terminal;

  // A start that would finish instantly is refused.
  assign start_blocked = count_up ? ((min_val == MaxMinBcd) && (sec_val == 8'h59))
                                  : ((min_val == 8'h00) && (sec_val == 8'h00));
  // Terminal value is reached by the step taken from these values.
  assign terminal      = dir_up_q ? ((min_val == MaxMinBcd) && (sec_val == 8'h58))
                                  : ((min_val == 8'h00) && (sec_val == 8'h01));

  assign set_edit = (state_q == StSet) && set_mode;
  // In SET the fields are independent; carry/borrow only applies to running steps.
  assign sec_inc  = (set_edit && inc_sec) || (step && dir_up_q);
  assign sec_dec  = step && !dir_up_q;
  assign min_inc  = (set_edit && inc_min) || (step && dir_up_q && sec_wrap);
  assign min_dec  = step && !dir_up_q && sec_wrap;

  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    preset_min_d = preset_min_q;
    preset_sec_d = preset_sec_q;
    dir_up_d     = dir_up_q;
    led_d        = led_q;
    step         = 1'b0;
    cnt_load     = 1'b0;
    if (set_mode) begin
      // Overrides everything; the current display becomes the editable value.
      state_d = StSet;
      led_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !start_blocked) begin
            preset_min_d = min_val;
            preset_sec_d = sec_val;
            dir_up_d     = count_up;
            sub_d        = '0;
            led_d        = LED_W'(1);
            state_d      = StRun;
          end
        end
        StSet: begin
          state_d = StIdle;
        end
        StRun: begin
          if (pause) begin
            state_d = StPause;
          end else if (tick) begin
            if (sub_q == SubLast) begin
              sub_d = '0;
              step  = 1'b1;
              if (terminal) begin
                state_d = StDone;
                led_d   = '1;
              end else begin
                led_d = (led_q << 1) | (led_q >> (LED_W - 1));
              end
            end else begin
              sub_d = sub_q + SubW'(1);
            end
          end
        end
        StPause: begin
          if (start && !pause) begin
            state_d = StRun;
          end
        end
        StDone: begin
          if (start) begin
            cnt_load = 1'b1;
            led_d    = '0;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sub_q        <= '0;
      preset_min_q <= '0;
      preset_sec_q <= '0;
      dir_up_q     <= 1'b0;
      led_q        <= '0;
      running_q    <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      preset_min_q <= preset_min_d;
      preset_sec_q <= preset_sec_d;
      dir_up_q     <= dir_up_d;
      led_q        <= led_d;
      running_q    <= (state_d == StRun);
      expired_q    <= (state_d == StDone);
    end
  end

  bcd_mod_counter #(
    .MAX(59)
  ) u_sec (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .inc_i     (sec_inc),
    .dec_i     (sec_dec),
    .load_i    (cnt_load),
    .load_val_i(preset_sec_q),
    .value_o   (sec_val),
    .wrap_o    (sec_wrap)
  );

  // Minutes never wrap while running: the terminal check stops the count first.
  bcd_mod_counter #(
    .MAX(MAX_MIN)
  ) u_min (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .inc_i     (min_inc),
    .dec_i     (min_dec),
    .load_i    (cnt_load),
    .load_val_i(preset_min_q),
    .value_o   (min_val),
    .wrap_o    (min_wrap_unused)
  );

  assign min_bcd = min_val;
  assign sec_bcd = sec_val;
  assign running = running_q;
  assign expired = expired_q;
  assign led     = led_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
module tb_countdown_timer_core;

  // Input encoding: {set_mode, inc_sec, inc_min, start, pause, count_up, tick}
  localparam logic [6:0] I_SET   = 7'b100_0000;
  localparam logic [6:0] I_ISEC  = 7'b010_0000;
  localparam logic [6:0] I_IMIN  = 7'b001_0000;
  localparam logic [6:0] I_START = 7'b000_1000;
  localparam logic [6:0] I_PAUSE = 7'b000_0100;
  localparam logic [6:0] I_UP    = 7'b000_0010;
  localparam logic [6:0] I_TICK  = 7'b000_0001;
  localparam logic [6:0] I_NONE  = 7'b000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick = 1'b0, set_mode = 1'b0, inc_sec = 1'b0, inc_min = 1'b0;
  logic        start = 1'b0, pause = 1'b0, count_up = 1'b0;
  logic [7:0]  min_bcd, sec_bcd;
  logic        running, expired;
  logic [15:0] led;

  countdown_timer_core #(
    .TICKS_PER_SEC(100),
    .MAX_MIN      (59),
    .LED_W        (16)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .set_mode(set_mode),
    .inc_sec (inc_sec),
    .inc_min (inc_min),
    .start   (start),
    .pause   (pause),
    .count_up(count_up),
    .min_bcd (min_bcd),
    .sec_bcd (sec_bcd),
    .running (running),
    .expired (expired),
    .led     (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  in;
    int unsigned reps;
    logic [7:0]  e_min;
    logic [7:0]  e_sec;
    logic        e_run;
    logic        e_exp;
    logic [15:0] e_led;
  } vec_t;

  typedef struct {
    vec_t        v;
    int unsigned due;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void add(input string n, input logic [6:0] in, input int unsigned reps,
                              input logic [7:0] mn, input logic [7:0] sc, input logic r,
                              input logic x, input logic [15:0] l);
    vec_t v;
    v.name = n; v.in = in; v.reps = reps;
    v.e_min = mn; v.e_sec = sc; v.e_run = r; v.e_exp = x; v.e_led = l;
    vecs.push_back(v);
  endfunction

  task automatic check_out(input string name, input logic [7:0] emin, input logic [7:0] esec,
                           input logic erun, input logic eexp, input logic [15:0] eled);
    checks++;
    if ({min_bcd, sec_bcd, running, expired, led} !== {emin, esec, erun, eexp, eled}) begin
      errors++;
      $display("FAIL %s: got %02h:%02h run=%0b exp=%0b led=%04h, want %02h:%02h run=%0b exp=%0b led=%04h",
               name, min_bcd, sec_bcd, running, expired, led, emin, esec, erun, eexp, eled);
    end
  endtask

  // At each falling edge: retire due scoreboard entries, then drive the next inputs.
  task automatic apply(input logic [6:0] in);
    exp_t e;
    @(negedge clk);
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check_out(e.v.name, e.v.e_min, e.v.e_sec, e.v.e_run, e.v.e_exp, e.v.e_led);
    end
    {set_mode, inc_sec, inc_min, start, pause, count_up, tick} = in;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    for (int r = 0; r < int'(v.reps); r++) apply(v.in);
    e.v   = v;
    e.due = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) apply(I_NONE);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: no output sampled, want %02h:%02h", e.v.name, e.v.e_min, e.v.e_sec);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // name, inputs, reps, min, sec, running, expired, led
    add("idle_hold",         I_NONE,                   1, 8'h00, 8'h00, 0, 0, 16'h0000);
    add("enter_set",         I_SET,                    1, 8'h00, 8'h00, 0, 0, 16'h0000);
    add("inc_sec_x3",        I_SET | I_ISEC,           3, 8'h00, 8'h03, 0, 0, 16'h0000);
    add("inc_min",           I_SET | I_IMIN,           1, 8'h01, 8'h03, 0, 0, 16'h0000);
    add("leave_set",         I_NONE,                   1, 8'h01, 8'h03, 0, 0, 16'h0000);
    add("start_down",        I_START,                  1, 8'h01, 8'h03, 1, 0, 16'h0001);
    add("ticks_299",         I_TICK,                 299, 8'h01, 8'h01, 1, 0, 16'h0004);
    add("tick_300",          I_TICK,                   1, 8'h01, 8'h00, 1, 0, 16'h0008);
    add("borrow_min",        I_TICK,                 100, 8'h00, 8'h59, 1, 0, 16'h0010);
    add("set_mid_run",       I_SET | I_TICK,           1, 8'h00, 8'h59, 0, 0, 16'h0000);
    add("inc_min_set",       I_SET | I_IMIN,           1, 8'h01, 8'h59, 0, 0, 16'h0000);
    add("sec_wrap_no_carry", I_SET | I_ISEC,           1, 8'h01, 8'h00, 0, 0, 16'h0000);
    add("inc_both",          I_SET | I_ISEC | I_IMIN,  1, 8'h02, 8'h01, 0, 0, 16'h0000);
    add("set_ignores_ctl",   I_SET | I_START | I_PAUSE, 1, 8'h02, 8'h01, 0, 0, 16'h0000);
    add("min_wrap",          I_SET | I_IMIN,          58, 8'h00, 8'h01, 0, 0, 16'h0000);
    add("preset_2s",         I_SET | I_ISEC,           1, 8'h00, 8'h02, 0, 0, 16'h0000);
    add("idle_2s",           I_NONE,                   1, 8'h00, 8'h02, 0, 0, 16'h0000);
    add("start_tick_ign",    I_START | I_TICK,         1, 8'h00, 8'h02, 1, 0, 16'h0001);
    add("ticks_199",         I_TICK,                 199, 8'h00, 8'h01, 1, 0, 16'h0002);
    add("expire",            I_TICK,                   1, 8'h00, 8'h00, 0, 1, 16'hFFFF);
    add("done_pause_ign",    I_PAUSE | I_TICK,         1, 8'h00, 8'h00, 0, 1, 16'hFFFF);
    add("done_hold",         I_TICK,                   5, 8'h00, 8'h00, 0, 1, 16'hFFFF);
    add("done_restart",      I_START,                  1, 8'h00, 8'h02, 0, 0, 16'h0000);
    add("start_again",       I_START,                  1, 8'h00, 8'h02, 1, 0, 16'h0001);
    add("ticks_50",          I_TICK,                  50, 8'h00, 8'h02, 1, 0, 16'h0001);
    add("pause_tick",        I_PAUSE | I_TICK,         1, 8'h00, 8'h02, 0, 0, 16'h0001);
    add("paused_500",        I_TICK,                 500, 8'h00, 8'h02, 0, 0, 16'h0001);
    add("resume",            I_START,                  1, 8'h00, 8'h02, 1, 0, 16'h0001);
    add("ticks_49",          I_TICK,                  49, 8'h00, 8'h02, 1, 0, 16'h0001);
    add("one_second",        I_TICK,                   1, 8'h00, 8'h01, 1, 0, 16'h0002);
    add("start_pause_run",   I_START | I_PAUSE | I_TICK, 1, 8'h00, 8'h01, 0, 0, 16'h0002);
    add("start_pause_pse",   I_START | I_PAUSE,        1, 8'h00, 8'h01, 0, 0, 16'h0002);
    add("resume2",           I_START,                  1, 8'h00, 8'h01, 1, 0, 16'h0002);
    add("set_again",         I_SET,                    1, 8'h00, 8'h01, 0, 0, 16'h0000);
    add("sec_to_zero",       I_SET | I_ISEC,          59, 8'h00, 8'h00, 0, 0, 16'h0000);
    add("idle_zero",         I_NONE,                   1, 8'h00, 8'h00, 0, 0, 16'h0000);
    add("down_zero_blocked", I_START,                  1, 8'h00, 8'h00, 0, 0, 16'h0000);
    add("set3",              I_SET,                    1, 8'h00, 8'h00, 0, 0, 16'h0000);
    add("min_to_59",         I_SET | I_IMIN,          59, 8'h59, 8'h00, 0, 0, 16'h0000);
    add("sec_to_59",         I_SET | I_ISEC,          59, 8'h59, 8'h59, 0, 0, 16'h0000);
    add("idle_max",          I_NONE,                   1, 8'h59, 8'h59, 0, 0, 16'h0000);
    add("up_max_blocked",    I_START | I_UP,           1, 8'h59, 8'h59, 0, 0, 16'h0000);
    add("set4",              I_SET,                    1, 8'h59, 8'h59, 0, 0, 16'h0000);
    add("sec_to_58",         I_SET | I_ISEC,          59, 8'h59, 8'h58, 0, 0, 16'h0000);
    add("idle_58",           I_NONE,                   1, 8'h59, 8'h58, 0, 0, 16'h0000);
    add("start_up",          I_START | I_UP,           1, 8'h59, 8'h58, 1, 0, 16'h0001);
    add("up_ticks_99",       I_TICK,                  99, 8'h59, 8'h58, 1, 0, 16'h0001);
    add("up_done",           I_TICK,                   1, 8'h59, 8'h59, 0, 1, 16'hFFFF);
    add("up_restart",        I_START,                  1, 8'h59, 8'h58, 0, 0, 16'h0000);
    add("set5",              I_SET,                    1, 8'h59, 8'h58, 0, 0, 16'h0000);
    add("min_wrap2",         I_SET | I_IMIN,           1, 8'h00, 8'h58, 0, 0, 16'h0000);
    add("sec_59",            I_SET | I_ISEC,           1, 8'h00, 8'h59, 0, 0, 16'h0000);
    add("idle_059",          I_NONE,                   1, 8'h00, 8'h59, 0, 0, 16'h0000);
    add("start_up2",         I_START | I_UP,           1, 8'h00, 8'h59, 1, 0, 16'h0001);
    add("up_carry",          I_TICK,                 100, 8'h01, 8'h00, 1, 0, 16'h0002);
    add("still_running",     I_TICK,                  30, 8'h01, 8'h00, 1, 0, 16'h0002);

    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_out("reset_initial", 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);
    drain();

    // Asynchronous reset mid-RUN: outputs clear before the next clock edge.
    #2 rst_n = 1'b0;
    {set_mode, inc_sec, inc_min, start, pause, count_up, tick} = I_NONE;
    #1 check_out("reset_mid_run", 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.delete();
    add("post_reset_idle",   I_TICK,                   1, 8'h00, 8'h00, 0, 0, 16'h0000);
    add("up_from_zero",      I_START | I_UP,           1, 8'h00, 8'h00, 1, 0, 16'h0001);
    add("up_first_sec",      I_TICK,                 100, 8'h00, 8'h01, 1, 0, 16'h0002);
    foreach (vecs[i]) run_vec(vecs[i]);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
